// File: rtl/shift_seq.sv
// Multi-cycle shift/rotate sequencer: one single-position step per clock until the amount is used up.
// Optional feature macro SHIFT_SEQ_OVF_EN enables SL overflow tracking; without it ovf is tied low.
`timescale 1ns/1ps
module shift_seq #(
   parameter int WIDTH = 4,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [AMT_W-1:0] amt,
   input  logic [WIDTH-1:0] din,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dout,
   output logic             ovf,
   output logic             err
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [2:0] OP_ILL = 3'b111;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] d_reg, d_nxt;
   logic [AMT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       opr, opr_nxt;
   logic             err_r, err_nxt;

   function automatic logic [WIDTH-1:0] step(input logic [2:0] o, input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] r;
      case (o)
         3'b000, 3'b100: r = {d[0], d[WIDTH-1:1]};
         3'b001, 3'b101: r = {d[WIDTH-2:0], d[WIDTH-1]};
         3'b010:         r = {1'b0, d[WIDTH-1:1]};
         3'b110:         r = {d[WIDTH-1], d[WIDTH-1:1]};
         3'b011:         r = {d[WIDTH-2:0], 1'b0};
         default:        r = d;
      endcase
      return r;
   endfunction

   always_comb begin
      state_nxt = state;
      d_nxt     = d_reg;
      cnt_nxt   = cnt;
      opr_nxt   = opr;
      err_nxt   = err_r;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               d_nxt   = din;
               cnt_nxt = amt;
               opr_nxt = op;
               err_nxt = (op == OP_ILL);
               // Illegal opcode or zero amount skips straight to completion with the operand untouched.
               if (amt == '0 || op == OP_ILL) state_nxt = DONE;
               else                           state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            d_nxt   = step(opr, d_reg);
            cnt_nxt = cnt - AMT_W'(1);
            if (cnt == AMT_W'(1)) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         d_reg <= '0;
         cnt   <= '0;
         opr   <= '0;
         err_r <= 1'b0;
      end else begin
         state <= state_nxt;
         d_reg <= d_nxt;
         cnt   <= cnt_nxt;
         opr   <= opr_nxt;
         err_r <= err_nxt;
      end
   end

`ifdef SHIFT_SEQ_OVF_EN
   logic ovf_r, ovf_nxt;

   // Sticky across the whole operation: any SL step that pushes out a 1 sets it.
   always_comb begin
      ovf_nxt = ovf_r;
      if (state == IDLE && start)
         ovf_nxt = 1'b0;
      else if (state == SHIFT && opr == 3'b011 && d_reg[WIDTH-1])
         ovf_nxt = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf_r <= 1'b0;
      else     ovf_r <= ovf_nxt;
   end

   assign ovf = ovf_r;
`else
   assign ovf = 1'b0;
`endif

   assign busy = (state != IDLE);
   assign dout = d_reg;
   assign err  = err_r;

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: expected results are queued at accept and compared on done.
`timescale 1ns/1ps
module tb_shift_seq;
   localparam int WIDTH = 4;
   localparam int AMT_W = 3;
`ifdef SHIFT_SEQ_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [2:0]       op;
   logic [AMT_W-1:0] amt;
   logic [WIDTH-1:0] din;
   logic             busy, done, ovf, err;
   logic [WIDTH-1:0] dout;

   shift_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .amt(amt), .din(din),
      .busy(busy), .done(done), .dout(dout), .ovf(ovf), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [WIDTH-1:0] dout;
      logic             ovf;
      logic             err;
      int               due;
   } exp_t;
   exp_t sbq[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Output monitor: every done must match the oldest queued expectation, including its cycle.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sbq.size() == 0) begin
            chk("spurious_done", {31'b0, done}, 32'd0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("dout", {28'b0, dout}, {28'b0, e.dout});
            chk("ovf", {31'b0, ovf}, {31'b0, e.ovf});
            chk("err", {31'b0, err}, {31'b0, e.err});
            chk("done_cycle", cyc, e.due);
         end
      end
   end

   function automatic void model(input logic [2:0] o, input logic [AMT_W-1:0] a,
                                 input logic [WIDTH-1:0] d, output logic [WIDTH-1:0] r,
                                 output logic v, output logic e);
      logic [7:0]        dd, t;
      logic [11:0]       w;
      logic signed [3:0] s;
      int                n;
      dd = {d, d};
      n  = int'(a) % WIDTH;
      s  = d;
      e  = (o == 3'b111);
      v  = 1'b0;
      r  = d;
      case (o)
         3'b000, 3'b100: begin t = dd >> n; r = t[3:0]; end
         3'b001, 3'b101: begin t = dd << n; r = t[7:4]; end
         3'b010: r = (a >= 3'd4) ? 4'b0000 : (d >> a);
         3'b110: r = s >>> a;
         3'b011: begin w = {8'b0, d} << a; r = w[3:0]; v = |w[11:4]; end
         default: r = d;
      endcase
   endfunction

   task automatic push_exp(input logic [2:0] o, input logic [AMT_W-1:0] a,
                           input logic [WIDTH-1:0] edout, input logic eovf, input logic eerr);
      exp_t e;
      e.dout = edout;
      e.ovf  = eovf & OVF_ON;
      e.err  = eerr;
      e.due  = cyc + ((o == 3'b111) ? 0 : int'(a));
      sbq.push_back(e);
   endtask

   task automatic run_op(input logic [2:0] o, input logic [AMT_W-1:0] a, input logic [WIDTH-1:0] d,
                         input logic [WIDTH-1:0] edout, input logic eovf, input logic eerr);
      int t;
      t = 0;
      @(negedge clk);
      while (busy && t < 60) begin
         @(negedge clk);
         t++;
      end
      if (busy) begin
         chk("idle_wait", {31'b0, busy}, 32'd0);
      end else begin
         op = o; amt = a; din = d; start = 1'b1;
         @(posedge clk);
         #1;
         push_exp(o, a, edout, eovf, eerr);
         start = 1'b0;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sbq.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("drain", sbq.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] r;
      logic             v, e;
      logic [2:0]       ro;
      logic [AMT_W-1:0] ra;
      logic [WIDTH-1:0] rd;
      int               k;

      rst = 1'b1; start = 1'b0; op = '0; amt = '0; din = '0;
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_dout", {28'b0, dout}, 32'd0);
      chk("rst_ovf", {31'b0, ovf}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      run_op(3'b000, 3'd1, 4'b1001, 4'b1100, 1'b0, 1'b0);
      run_op(3'b110, 3'd3, 4'b1001, 4'b1111, 1'b0, 1'b0);
      run_op(3'b010, 3'd3, 4'b1001, 4'b0001, 1'b0, 1'b0);
      run_op(3'b001, 3'd3, 4'b1001, 4'b1100, 1'b0, 1'b0);
      run_op(3'b011, 3'd2, 4'b0110, 4'b1000, 1'b1, 1'b0);
      run_op(3'b011, 3'd1, 4'b0110, 4'b1100, 1'b0, 1'b0);
      run_op(3'b000, 3'd0, 4'b1010, 4'b1010, 1'b0, 1'b0);
      run_op(3'b111, 3'd5, 4'b0101, 4'b0101, 1'b0, 1'b1);
      run_op(3'b010, 3'd6, 4'b1111, 4'b0000, 1'b0, 1'b0);
      run_op(3'b110, 3'd7, 4'b1000, 4'b1111, 1'b0, 1'b0);
      drain();

      // Start held high: the request must be ignored while busy and re-accepted right after done.
      @(negedge clk);
      op = 3'b000; amt = 3'd7; din = 4'b0001; start = 1'b1;
      @(posedge clk);
      #1;
      k = cyc;
      push_exp(3'b000, 3'd7, 4'b0010, 1'b0, 1'b0);
      repeat (8) @(posedge clk);
      #1;
      chk("held_idle_gap", {31'b0, busy}, 32'd0);
      @(posedge clk);
      #1;
      chk("held_second_accept", {31'b0, busy}, 32'd1);
      chk("held_accept_cycle", cyc, k + 9);
      push_exp(3'b000, 3'd7, 4'b0010, 1'b0, 1'b0);
      start = 1'b0;
      drain();

      // Reset in the middle of an operation, with the next request already waiting on release.
      run_op(3'b001, 3'd5, 4'b0011, 4'b0110, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      sbq.delete();
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_done", {31'b0, done}, 32'd0);
      chk("midrst_dout", {28'b0, dout}, 32'd0);
      chk("midrst_ovf", {31'b0, ovf}, 32'd0);
      chk("midrst_err", {31'b0, err}, 32'd0);
      op = 3'b001; amt = 3'd1; din = 4'b1000; start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("release_accept", {31'b0, busy}, 32'd1);
      push_exp(3'b001, 3'd1, 4'b0001, 1'b0, 1'b0);
      start = 1'b0;
      drain();

      for (int i = 0; i < 16; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = 3'($urandom_range(0, 7));
         rd = 4'($urandom_range(0, 15));
         model(ro, ra, rd, r, v, e);
         run_op(ro, ra, rd, r, v, e);
      end
      drain();

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
